// File: rtl/rtc_alarm_scheduler.sv
// rtc_alarm_scheduler: four-slot RTC alarm table. Each slot holds a 17-bit
// tag that is compared against curr_time[31:15]; a rising match sets the
// slot's pending bit and a presentation FSM hands pending alarms to the
// consumer one at a time. Optional macro RTC_ALARM_RR_EN switches the
// pending-slot arbitration from fixed lowest-index to round-robin.
module rtc_alarm_scheduler (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] curr_time,
  input  logic        add_req,
  input  logic [16:0] add_tag,
  output logic        add_ack,
  output logic        add_err,
  output logic [1:0]  add_slot,
  input  logic        del_req,
  input  logic [1:0]  del_slot,
  output logic        alarm_valid,
  output logic [1:0]  alarm_slot,
  input  logic        alarm_ack,
  output logic [31:0] alarm1,
  output logic [31:0] alarm2,
  output logic [31:0] alarm3,
  output logic [31:0] alarm4,
  output logic [7:0]  miss_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, PRESENT = 2'd1, GAP = 2'd2} state_t;

  state_t      state_q;
  logic        alarm_valid_q;
  logic [1:0]  alarm_slot_q;
  logic [16:0] tag_q [4];
  logic [16:0] tag_d [4];
  logic [31:0] alarm_img_q [4];
  logic [3:0]  valid_q, valid_d, pend_q, pend_d, hist_q, hist_d;
  logic [7:0]  miss_q, miss_d;
  logic        add_ack_q, add_ack_d, add_err_q, add_err_d;
  logic [1:0]  add_slot_q, add_slot_d;
  logic [16:0] cur_tag_s;
  logic        unused_time_s;
  logic [3:0]  del_mask_s, clr_mask_s, edge_s, dup_s;
  logic        del_hit_s, ack_fire_s;
  logic        dup_hit_s, free_hit_s;
  logic [1:0]  dup_idx_s, free_idx_s;
  logic [2:0]  miss_inc_s;
  logic [8:0]  miss_sum_s;
  logic        sel_found_s;
  logic [1:0]  sel_idx_s, sel_base_s, sel_try_s;
`ifdef RTC_ALARM_RR_EN
  logic [1:0]  rr_ptr_q;
`endif

  // Low time bits are below the match granularity.
  assign cur_tag_s     = curr_time[31:15];
  assign unused_time_s = ^curr_time[14:0];

  // Deleting the presented slot aborts the presentation; it outranks an ack.
  assign del_hit_s  = (state_q == PRESENT) && del_req && (del_slot == alarm_slot_q);
  assign ack_fire_s = (state_q == PRESENT) && alarm_ack && !del_hit_s;

  // Slot table next state: match edges, delete/ack clears, then add allocation.
  always_comb begin
    del_mask_s = 4'b0000;
    edge_s     = 4'b0000;
    dup_s      = 4'b0000;
    miss_inc_s = 3'd0;
    dup_hit_s  = 1'b0;
    dup_idx_s  = 2'd0;
    free_hit_s = 1'b0;
    free_idx_s = 2'd0;
    add_ack_d  = 1'b0;
    add_err_d  = 1'b0;
    add_slot_d = add_slot_q;
    hist_d     = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tag_d[i] = tag_q[i];
    end
    if (del_req) begin
      del_mask_s[del_slot] = 1'b1;
    end else begin
      del_mask_s = 4'b0000;
    end
    clr_mask_s = del_mask_s;
    if (ack_fire_s) begin
      clr_mask_s[alarm_slot_q] = 1'b1;
    end else begin
      clr_mask_s = del_mask_s;
    end
    for (int i = 0; i < 4; i++) begin
      edge_s[i] = valid_q[i] && (tag_q[i] == cur_tag_s) && !hist_q[i];
      // A slot being deleted this cycle no longer answers duplicates.
      dup_s[i]  = valid_q[i] && !del_mask_s[i] && (tag_q[i] == add_tag);
      if (edge_s[i] && pend_q[i]) begin
        miss_inc_s = miss_inc_s + 3'd1;
      end else begin
        miss_inc_s = miss_inc_s;
      end
    end
    // Scan downwards so the lowest index is the last one written.
    for (int i = 3; i >= 0; i--) begin
      if (dup_s[i]) begin
        dup_hit_s = 1'b1;
        dup_idx_s = 2'(i);
      end else begin
        dup_hit_s = dup_hit_s;
      end
      // Free-ness uses the pre-delete view so a deleting slot stays occupied.
      if (!valid_q[i]) begin
        free_hit_s = 1'b1;
        free_idx_s = 2'(i);
      end else begin
        free_hit_s = free_hit_s;
      end
    end
    pend_d  = (pend_q | edge_s) & ~clr_mask_s;
    valid_d = valid_q & ~clr_mask_s;
    for (int i = 0; i < 4; i++) begin
      if (clr_mask_s[i]) begin
        tag_d[i] = 17'd0;
      end else begin
        tag_d[i] = tag_q[i];
      end
    end
    if (add_req) begin
      if (dup_hit_s) begin
        add_ack_d  = 1'b1;
        add_slot_d = dup_idx_s;
      end else if (free_hit_s) begin
        add_ack_d             = 1'b1;
        add_slot_d            = free_idx_s;
        valid_d[free_idx_s]   = 1'b1;
        pend_d[free_idx_s]    = 1'b0;
        tag_d[free_idx_s]     = add_tag;
      end else begin
        add_err_d = 1'b1;
      end
    end else begin
      add_ack_d = 1'b0;
    end
    // History follows the next tag, so a tag already matching at add time
    // must see a non-match before it can fire.
    for (int i = 0; i < 4; i++) begin
      hist_d[i] = (tag_d[i] == cur_tag_s);
    end
    miss_sum_s = {1'b0, miss_q} + {6'd0, miss_inc_s};
    miss_d     = miss_sum_s[8] ? 8'hFF : miss_sum_s[7:0];
  end

  // Pick the next pending slot, skipping one being deleted this cycle.
  always_comb begin
`ifdef RTC_ALARM_RR_EN
    sel_base_s = rr_ptr_q;
`else
    sel_base_s = 2'd0;
`endif
    sel_found_s = 1'b0;
    sel_idx_s   = 2'd0;
    sel_try_s   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      sel_try_s = sel_base_s + 2'(k);
      if (!sel_found_s && pend_q[sel_try_s] && !del_mask_s[sel_try_s]) begin
        sel_found_s = 1'b1;
        sel_idx_s   = sel_try_s;
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Slot table, add response and miss counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 4'b0000;
      pend_q     <= 4'b0000;
      hist_q     <= 4'b0000;
      miss_q     <= 8'd0;
      add_ack_q  <= 1'b0;
      add_err_q  <= 1'b0;
      add_slot_q <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        tag_q[i]       <= 17'd0;
        alarm_img_q[i] <= 32'd0;
      end
    end else begin
      valid_q    <= valid_d;
      pend_q     <= pend_d;
      hist_q     <= hist_d;
      miss_q     <= miss_d;
      add_ack_q  <= add_ack_d;
      add_err_q  <= add_err_d;
      add_slot_q <= add_slot_d;
      for (int i = 0; i < 4; i++) begin
        tag_q[i]       <= tag_d[i];
        alarm_img_q[i] <= {tag_d[i], valid_d[i], 14'd0};
      end
    end
  end

  // Presentation FSM with registered alarm_valid / alarm_slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      alarm_valid_q <= 1'b0;
      alarm_slot_q  <= 2'd0;
`ifdef RTC_ALARM_RR_EN
      rr_ptr_q      <= 2'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_found_s) begin
            state_q       <= PRESENT;
            alarm_valid_q <= 1'b1;
            alarm_slot_q  <= sel_idx_s;
`ifdef RTC_ALARM_RR_EN
            rr_ptr_q      <= sel_idx_s + 2'd1;
`endif
          end else begin
            alarm_valid_q <= 1'b0;
          end
        end
        PRESENT: begin
          if (del_hit_s) begin
            state_q       <= IDLE;
            alarm_valid_q <= 1'b0;
          end else if (alarm_ack) begin
            state_q       <= GAP;
            alarm_valid_q <= 1'b0;
          end else begin
            alarm_valid_q <= 1'b1;
          end
        end
        GAP: begin
          state_q       <= IDLE;
          alarm_valid_q <= 1'b0;
        end
        default: begin
          state_q       <= IDLE;
          alarm_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign add_ack     = add_ack_q;
  assign add_err     = add_err_q;
  assign add_slot    = add_slot_q;
  assign alarm_valid = alarm_valid_q;
  assign alarm_slot  = alarm_slot_q;
  assign alarm1      = alarm_img_q[0];
  assign alarm2      = alarm_img_q[1];
  assign alarm3      = alarm_img_q[2];
  assign alarm4      = alarm_img_q[3];
  assign miss_cnt    = miss_q;

endmodule

// File: tb/tb_rtc_alarm_scheduler.sv
// Directed bench for rtc_alarm_scheduler (default fixed-priority build).
module tb_rtc_alarm_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] curr_time;
  logic        add_req;
  logic [16:0] add_tag;
  logic        add_ack, add_err;
  logic [1:0]  add_slot;
  logic        del_req;
  logic [1:0]  del_slot;
  logic        alarm_valid;
  logic [1:0]  alarm_slot;
  logic        alarm_ack;
  logic [31:0] alarm1, alarm2, alarm3, alarm4;
  logic [7:0]  miss_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        add;
    logic [16:0] tag;
    logic        del;
    logic [1:0]  dslot;
    logic        ack;
    logic        e_ack;
    logic        e_err;
    logic [1:0]  e_slot;
  } vec_t;

  vec_t vt [9];

  rtc_alarm_scheduler dut (
    .clk(clk), .reset(reset), .curr_time(curr_time),
    .add_req(add_req), .add_tag(add_tag), .add_ack(add_ack), .add_err(add_err),
    .add_slot(add_slot), .del_req(del_req), .del_slot(del_slot),
    .alarm_valid(alarm_valid), .alarm_slot(alarm_slot), .alarm_ack(alarm_ack),
    .alarm1(alarm1), .alarm2(alarm2), .alarm3(alarm3), .alarm4(alarm4),
    .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ct(input logic [16:0] t);
    curr_time = {t, 15'h5A5A};
  endtask

  task automatic add_chk(input logic [16:0] t, input logic [1:0] s, input string nm);
    add_req = 1'b1;
    add_tag = t;
    step();
    add_req = 1'b0;
    chk({nm, " ack"}, {31'd0, add_ack}, 32'd1);
    chk({nm, " slot"}, {30'd0, add_slot}, {30'd0, s});
  endtask

  task automatic av_chk(input string nm, input logic v, input logic [1:0] s);
    chk({nm, " valid"}, {31'd0, alarm_valid}, {31'd0, v});
    if (v) chk({nm, " slot"}, {30'd0, alarm_slot}, {30'd0, s});
  endtask

  task automatic ack_step(input string nm);
    alarm_ack = 1'b1;
    step();
    alarm_ack = 1'b0;
    av_chk(nm, 1'b0, 2'd0);
  endtask

  initial begin
    logic [31:0] img;
    vt[0] = '{1'b1, 17'h00010, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0};
    vt[1] = '{1'b1, 17'h00020, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd1};
    vt[2] = '{1'b1, 17'h00030, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd2};
    vt[3] = '{1'b1, 17'h00040, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd3};
    vt[4] = '{1'b1, 17'h00050, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0};
    vt[5] = '{1'b1, 17'h00020, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd1};
    vt[6] = '{1'b0, 17'h00000, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0};
    vt[7] = '{1'b1, 17'h00055, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 2'd0};
    vt[8] = '{1'b1, 17'h00040, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd3};

    reset = 1'b1; add_req = 1'b0; add_tag = 17'd0; del_req = 1'b0;
    del_slot = 2'd0; alarm_ack = 1'b0; curr_time = 32'd0;
    step();
    step();
    chk("rst add_ack", {31'd0, add_ack}, 32'd0);
    chk("rst add_err", {31'd0, add_err}, 32'd0);
    chk("rst add_slot", {30'd0, add_slot}, 32'd0);
    chk("rst alarm_valid", {31'd0, alarm_valid}, 32'd0);
    chk("rst alarm_slot", {30'd0, alarm_slot}, 32'd0);
    chk("rst alarm1", alarm1, 32'd0);
    chk("rst alarm4", alarm4, 32'd0);
    chk("rst miss_cnt", {24'd0, miss_cnt}, 32'd0);
    reset = 1'b0;
    set_ct(17'h00000);

    // Fill, full, duplicate, ignored ack, add+delete same cycle.
    for (int i = 0; i < 9; i++) begin
      add_req = vt[i].add; add_tag = vt[i].tag;
      del_req = vt[i].del; del_slot = vt[i].dslot; alarm_ack = vt[i].ack;
      step();
      chk($sformatf("vec%0d ack", i), {31'd0, add_ack}, {31'd0, vt[i].e_ack});
      chk($sformatf("vec%0d err", i), {31'd0, add_err}, {31'd0, vt[i].e_err});
      chk($sformatf("vec%0d valid", i), {31'd0, alarm_valid}, 32'd0);
      if (vt[i].e_ack) chk($sformatf("vec%0d slot", i), {30'd0, add_slot}, {30'd0, vt[i].e_slot});
    end
    add_req = 1'b0; del_req = 1'b0; alarm_ack = 1'b0;
    img = {17'h00040, 1'b1, 14'd0};
    chk("a alarm4", alarm4, img);
    img = {17'h00010, 1'b1, 14'd0};
    chk("a alarm1", alarm1, img);

    // Single alarm on slot 1, acked after 3 held cycles.
    set_ct(17'h0001F); step(); av_chk("b pre", 1'b0, 2'd0);
    set_ct(17'h00020); step(); av_chk("b match", 1'b0, 2'd0);
    step(); av_chk("b present", 1'b1, 2'd1);
    for (int i = 0; i < 3; i++) begin
      step(); av_chk("b hold", 1'b1, 2'd1);
    end
    ack_step("b ack");
    chk("b alarm2", alarm2, 32'd0);
    ack_step("b gap");
    step(); av_chk("b idle", 1'b0, 2'd0);
    img = {17'h00030, 1'b1, 14'd0};
    chk("b alarm3", alarm3, img);

    // Slots 2 then 0 go pending while slot 1 is presented: 0 wins first.
    add_chk(17'h00021, 2'd1, "c add");
    set_ct(17'h00021); step(); av_chk("c match", 1'b0, 2'd0);
    step(); av_chk("c present1", 1'b1, 2'd1);
    set_ct(17'h00030); step(); av_chk("c hold a", 1'b1, 2'd1);
    set_ct(17'h00010); step(); av_chk("c hold b", 1'b1, 2'd1);
    ack_step("c ack1");
    step(); av_chk("c gap1", 1'b0, 2'd0);
    step(); av_chk("c first", 1'b1, 2'd0);
    ack_step("c ack0");
    chk("c alarm1", alarm1, 32'd0);
    step(); av_chk("c gap0", 1'b0, 2'd0);
    step(); av_chk("c second", 1'b1, 2'd2);
    ack_step("c ack2");
    chk("c alarm3", alarm3, 32'd0);
    step(); step(); av_chk("c idle", 1'b0, 2'd0);
    chk("c miss", {24'd0, miss_cnt}, 32'd0);

    // Tag already matching at add does not fire; repeated misses saturate.
    add_chk(17'h00010, 2'd0, "d add");
    step(); step(); av_chk("d nofire", 1'b0, 2'd0);
    set_ct(17'h00011); step();
    set_ct(17'h00010); step(); av_chk("d match", 1'b0, 2'd0);
    step(); av_chk("d present", 1'b1, 2'd0);
    set_ct(17'h00011); step();
    set_ct(17'h00010); step();
    chk("d miss1", {24'd0, miss_cnt}, 32'd1);
    for (int i = 0; i < 300; i++) begin
      set_ct(17'h00011); step();
      set_ct(17'h00010); step();
    end
    chk("d miss sat", {24'd0, miss_cnt}, 32'd255);
    av_chk("d still", 1'b1, 2'd0);
    ack_step("d ack");
    step(); step(); av_chk("d idle", 1'b0, 2'd0);

    // Delete the presented slot 3, then re-add into it.
    add_chk(17'h00081, 2'd0, "e add0");
    add_chk(17'h00082, 2'd1, "e add1");
    add_chk(17'h00083, 2'd2, "e add2");
    set_ct(17'h00040); step();
    step(); av_chk("e present", 1'b1, 2'd3);
    del_req = 1'b1; del_slot = 2'd3;
    step();
    del_req = 1'b0;
    av_chk("e del", 1'b0, 2'd0);
    chk("e alarm4", alarm4, 32'd0);
    add_chk(17'h00099, 2'd3, "e readd");

    // Reset during presentation wins over a concurrent add.
    set_ct(17'h00099); step();
    step(); av_chk("f present", 1'b1, 2'd3);
    reset = 1'b1; add_req = 1'b1; add_tag = 17'h00055;
    step();
    reset = 1'b0; add_req = 1'b0;
    chk("f valid", {31'd0, alarm_valid}, 32'd0);
    chk("f slot", {30'd0, alarm_slot}, 32'd0);
    chk("f add_ack", {31'd0, add_ack}, 32'd0);
    chk("f add_slot", {30'd0, add_slot}, 32'd0);
    chk("f alarm1", alarm1, 32'd0);
    chk("f alarm4", alarm4, 32'd0);
    chk("f miss", {24'd0, miss_cnt}, 32'd0);
    ack_step("f ack ignored");
    step(); av_chk("f idle", 1'b0, 2'd0);
    chk("f alarm4 after", alarm4, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
